// File: rtl/memshare_alloc_sched.sv
// Allocation-sequence scheduler: buffers request patterns, resolves shared-column
// bank conflicts into ranked sequences and streams one grant mask per sequence.
module memshare_alloc_sched #(
  parameter int unsigned             GRP_SIZE    = 5,
  parameter int unsigned             ADDR_W      = 3,
  parameter int unsigned             MAX_SEQ     = 2,
  parameter int unsigned             TRACK_DEPTH = 4,
  parameter logic [GRP_SIZE-1:0]     SHARE_MASK  = 5'b10101,
  parameter int unsigned             CNT_W       = 16
) (
  input  logic                         sys_clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [GRP_SIZE-1:0]          in_flag,
  input  logic [GRP_SIZE*ADDR_W-1:0]   in_addr,
  output logic                         seq_valid,
  input  logic                         seq_ready,
  output logic [GRP_SIZE-1:0]          seq_grant,
  output logic [$clog2(MAX_SEQ):0]     seq_idx,
  output logic                         seq_last,
  input  logic                         stat_clr,
  output logic [CNT_W-1:0]             stat_multi_cnt,
  output logic [CNT_W-1:0]             stat_pat_cnt,
  output logic                         drc_ovf
);

  localparam int unsigned IDX_W    = $clog2(MAX_SEQ) + 1;
  localparam int unsigned PTR_W    = $clog2(TRACK_DEPTH);
  localparam int unsigned CNTF_W   = PTR_W + 1;
  localparam int unsigned RANK_MAX = (GRP_SIZE > MAX_SEQ) ? GRP_SIZE : MAX_SEQ;
  localparam int unsigned RANK_W   = $clog2(RANK_MAX + 1);
  localparam int unsigned MASK_W   = MAX_SEQ * GRP_SIZE;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                      r_state, w_state_nxt;
  logic                        w_load, w_push, w_empty, w_last, w_ovf;

  logic [GRP_SIZE-1:0]         r_fifo_flag [TRACK_DEPTH];
  logic [GRP_SIZE*ADDR_W-1:0]  r_fifo_addr [TRACK_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CNTF_W-1:0]           r_count;
  logic [GRP_SIZE-1:0]         w_head_flag;
  logic [GRP_SIZE*ADDR_W-1:0]  w_head_addr;

  logic [GRP_SIZE-1:0][GRP_SIZE-1:0] w_hit;
  logic [RANK_W-1:0]           w_rank [GRP_SIZE];
  logic [GRP_SIZE-1:0]         w_drop;
  logic [MASK_W-1:0]           w_masks;
  logic [MAX_SEQ-1:0]          w_used;
  logic [IDX_W-1:0]            w_nseq;

  logic [MASK_W-1:0]           r_masks;
  logic [IDX_W-1:0]            r_nseq, r_idx;
  logic [CNT_W-1:0]            r_pat_cnt, r_multi_cnt;
  logic                        r_ovf;

  assign in_ready    = (r_count != CNTF_W'(TRACK_DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_empty     = (r_count == '0);
  assign w_head_flag = r_fifo_flag[r_rd_ptr];
  assign w_head_addr = r_fifo_addr[r_rd_ptr];

  // Pattern storage carries no reset; validity is tracked by the count.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_fifo_flag[r_wr_ptr] <= in_flag;
      r_fifo_addr[r_wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNTF_W'(1);
        2'b01:   r_count <= r_count - CNTF_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Rank of a shared requestor = number of earlier shared, flagged requestors on the same bank.
  for (genvar gi = 0; gi < GRP_SIZE; gi++) begin : g_req
    for (genvar gj = 0; gj < GRP_SIZE; gj++) begin : g_cmp
      if (gj < gi) begin : g_lo
        assign w_hit[gi][gj] = SHARE_MASK[gi] && SHARE_MASK[gj] && w_head_flag[gj] &&
                               (w_head_addr[gj*ADDR_W +: ADDR_W] == w_head_addr[gi*ADDR_W +: ADDR_W]);
      end else begin : g_hi
        assign w_hit[gi][gj] = 1'b0;
      end
    end
    assign w_rank[gi] = RANK_W'($countones(w_hit[gi]));
    assign w_drop[gi] = w_head_flag[gi] && (w_rank[gi] >= RANK_W'(MAX_SEQ));
  end

  for (genvar gs = 0; gs < MAX_SEQ; gs++) begin : g_seq
    for (genvar gi = 0; gi < GRP_SIZE; gi++) begin : g_bit
      assign w_masks[gs*GRP_SIZE + gi] = w_head_flag[gi] && (w_rank[gi] == RANK_W'(gs));
    end
    assign w_used[gs] = |w_masks[gs*GRP_SIZE +: GRP_SIZE];
  end

  // Ranks are contiguous from 0, so the populated sequences form a thermometer.
  assign w_ovf  = |w_drop;
  assign w_nseq = (w_used == '0) ? IDX_W'(1) : IDX_W'($countones(w_used));

  assign w_last         = (r_idx == (r_nseq - IDX_W'(1)));
  assign seq_valid      = (r_state == S_EMIT);
  assign seq_last       = seq_valid && w_last;
  assign seq_idx        = r_idx;
  assign seq_grant      = seq_valid ? GRP_SIZE'(r_masks >> (32'(r_idx) * GRP_SIZE)) : '0;
  assign stat_pat_cnt   = r_pat_cnt;
  assign stat_multi_cnt = r_multi_cnt;
  assign drc_ovf        = r_ovf;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (seq_ready && w_last) begin
          if (!w_empty) w_load      = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_masks <= '0;
      r_nseq  <= IDX_W'(1);
      r_idx   <= '0;
    end else begin
      if (w_load) begin
        r_masks <= w_masks;
        r_nseq  <= w_nseq;
      end
      if (w_load || (seq_valid && seq_ready && w_last)) r_idx <= '0;
      else if (seq_valid && seq_ready)                  r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Clear beats a same-cycle increment; an overflowing load still raises the flag.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_pat_cnt   <= '0;
      r_multi_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (stat_clr) begin
        r_pat_cnt   <= '0;
        r_multi_cnt <= '0;
      end else if (w_load) begin
        if (r_pat_cnt != '1)                              r_pat_cnt   <= r_pat_cnt + CNT_W'(1);
        if ((w_nseq > IDX_W'(1)) && (r_multi_cnt != '1))  r_multi_cnt <= r_multi_cnt + CNT_W'(1);
      end
      r_ovf <= (r_ovf && !stat_clr) || (w_load && w_ovf);
    end
  end

endmodule
